// File: rtl/syndrome_checker.sv
// Bit-serial front end of the (15,7) majority-logic decoder: collects a codeword,
// accumulates its H715 syndrome on the fly and hands both over through a one-word buffer.
module syndrome_checker #(
  parameter int N = 15,
  parameter int M = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic [N-1:0] cw,
  output logic [M-1:0] syndrome,
  output logic         error,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam logic [3:0] LAST_IDX = 4'(N - 1);

  typedef enum logic {
    BUF_EMPTY,
    BUF_FULL
  } buf_state_t;

  buf_state_t   r_state;
  buf_state_t   w_state_next;
  logic [3:0]   r_idx;
  logic [N-1:0] r_asm;
  logic [M-1:0] r_acc;
  logic [N-1:0] r_cw;
  logic [M-1:0] r_syn;

  logic         w_last;
  logic         w_accept;
  logic         w_complete;
  logic         w_pop;
  logic [M-1:0] w_col;
  logic [N-1:0] w_asm_next;
  logic [M-1:0] w_acc_next;

  // Columns of H715; bits 8..14 are x^j mod g(x), g = x^8+x^7+x^6+x^4+1.
  always_comb begin
    w_col = '0;
    case (r_idx)
      4'd0:  w_col = 8'h01;
      4'd1:  w_col = 8'h02;
      4'd2:  w_col = 8'h04;
      4'd3:  w_col = 8'h08;
      4'd4:  w_col = 8'h10;
      4'd5:  w_col = 8'h20;
      4'd6:  w_col = 8'h40;
      4'd7:  w_col = 8'h80;
      4'd8:  w_col = 8'hD1;
      4'd9:  w_col = 8'h73;
      4'd10: w_col = 8'hE6;
      4'd11: w_col = 8'h1D;
      4'd12: w_col = 8'h3A;
      4'd13: w_col = 8'h74;
      4'd14: w_col = 8'hE8;
      default: w_col = '0;
    endcase
  end

  assign w_last     = (r_idx == LAST_IDX);
  assign w_pop      = (r_state == BUF_FULL) && out_ready;
  // Only the final bit depends on buffer space, so a busy corrector stalls just that bit.
  assign din_ready  = !w_last || (r_state == BUF_EMPTY) || out_ready;
  assign w_accept   = din_valid && din_ready;
  assign w_complete = w_accept && w_last;

  always_comb begin
    w_asm_next        = r_asm;
    w_asm_next[r_idx] = din;
    w_acc_next        = din ? (r_acc ^ w_col) : r_acc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx <= '0;
      r_asm <= '0;
      r_acc <= '0;
    end else if (w_accept) begin
      if (w_last) begin
        r_idx <= '0;
        r_asm <= '0;
        r_acc <= '0;
      end else begin
        r_idx <= r_idx + 4'd1;
        r_asm <= w_asm_next;
        r_acc <= w_acc_next;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      BUF_EMPTY: if (w_complete) w_state_next = BUF_FULL;
      BUF_FULL:  if (w_pop && !w_complete) w_state_next = BUF_EMPTY;
      default:   w_state_next = BUF_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= BUF_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cw  <= '0;
      r_syn <= '0;
    end else if (w_complete) begin
      r_cw  <= w_asm_next;
      r_syn <= w_acc_next;
    end
  end

  assign cw        = r_cw;
  assign syndrome  = r_syn;
  assign error     = |r_syn;
  assign out_valid = (r_state == BUF_FULL);

endmodule

// File: tb/tb_syndrome_checker.sv
// Bench for syndrome_checker: syndrome predicted as the remainder of cw(x) mod g(x),
// buffer/handshake behaviour predicted with a queue of completed words.
module tb_syndrome_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        din = 1'b0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic [14:0] cw;
  logic [7:0]  syndrome;
  logic        error;
  logic        out_valid;
  logic        out_ready = 1'b0;

  int compared = 0;
  int mismatched = 0;
  bit rand_ready = 1'b0;

  syndrome_checker #(.N(15), .M(8)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .cw(cw), .syndrome(syndrome), .error(error), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Syndrome of a received word = cw(x) mod g(x), g(x) = 0x1D1.
  function automatic logic [7:0] poly_rem(input logic [14:0] w);
    logic [14:0] r;
    r = w;
    for (int k = 14; k >= 8; k--)
      if (r[k]) r = r ^ (15'h01D1 << (k - 8));
    return r[7:0];
  endfunction

  logic [14:0] m_asm = '0;
  int          m_cnt = 0;
  logic [14:0] m_q[$];

  always @(negedge clk) begin
    logic exp_ready;
    if (rst) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_cw", cw, 0);
      chk("rst_syndrome", syndrome, 0);
      chk("rst_error", error, 0);
      m_q.delete();
      m_cnt = 0;
      m_asm = '0;
    end else begin
      exp_ready = (m_cnt != 14) || (m_q.size() == 0) || out_ready;
      chk("din_ready", din_ready, exp_ready);
      chk("out_valid", out_valid, m_q.size() != 0);
      if (m_q.size() != 0) begin
        chk("cw", cw, m_q[0]);
        chk("syndrome", syndrome, poly_rem(m_q[0]));
        chk("error", error, |poly_rem(m_q[0]));
      end
      if (m_q.size() != 0 && out_ready) void'(m_q.pop_front());
      if (din_valid && exp_ready) begin
        m_asm[m_cnt] = din;
        if (m_cnt == 14) begin
          m_q.push_back(m_asm);
          m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic wait_accept();
    int   n;
    logic a;
    n = 0;
    do begin
      @(negedge clk);
      a = din_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!a && n < 100);
    if (!a) chk("accept_timeout", 0, 1);
  endtask

  task automatic send_bits(input logic [14:0] w, input int lo, input int hi, input bit gaps);
    for (int j = lo; j <= hi; j++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        din_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      din_valid = 1'b1;
      din = w[j];
      wait_accept();
    end
    din_valid = 1'b0;
    din = 1'b0;
  endtask

  task automatic directed_frame(input string nm, input logic [14:0] w,
                                input logic [7:0] exp_syn, input logic exp_err);
    send_bits(w, 0, 14, 1'b0);
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_cw"}, cw, w);
    chk({nm, "_syn"}, syndrome, exp_syn);
    chk({nm, "_err"}, error, exp_err);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [14:0] a_w;
    logic [14:0] b_w;
    int          n;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("reset_din_ready", din_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    @(posedge clk);
    #1;

    directed_frame("zero", 15'h0000, 8'h00, 1'b0);
    directed_frame("bit8", 15'h0100, 8'hD1, 1'b1);
    directed_frame("bit0", 15'h0001, 8'h01, 1'b1);
    directed_frame("bit14", 15'h4000, 8'hE8, 1'b1);
    directed_frame("codeword", 15'h01D1, 8'h00, 1'b0);

    // Back-to-back with the corrector stalled.
    a_w = 15'h0100;
    b_w = 15'h4000;
    out_ready = 1'b0;
    send_bits(a_w, 0, 14, 1'b0);
    chk("b2b_a_valid", out_valid, 1);
    send_bits(b_w, 0, 13, 1'b0);
    din_valid = 1'b1;
    din = b_w[14];
    repeat (3) begin
      @(negedge clk);
      chk("b2b_stall_ready", din_ready, 0);
      chk("b2b_hold_cw", cw, a_w);
      chk("b2b_hold_syn", syndrome, 8'hD1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("b2b_release_ready", din_ready, 1);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    din_valid = 1'b0;
    din = 1'b0;
    chk("b2b_b_valid", out_valid, 1);
    chk("b2b_b_cw", cw, b_w);
    chk("b2b_b_syn", syndrome, 8'hE8);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("b2b_drained", out_valid, 0);

    // Reset mid-frame: partial frame must leave no residue.
    send_bits(15'h7FFF, 0, 6, 1'b0);
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", out_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    directed_frame("after_rst", 15'h0000, 8'h00, 1'b0);

    // Reset with the buffer full: buffered word is dropped.
    out_ready = 1'b0;
    send_bits(15'h0100, 0, 14, 1'b0);
    chk("rst_full_pre", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("rst_full_valid", out_valid, 0);
    chk("rst_full_cw", cw, 0);
    chk("rst_full_syn", syndrome, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_full_dropped", out_valid, 0);

    // Randomised frames with random input gaps and random corrector back-pressure.
    rand_ready = 1'b1;
    for (int f = 0; f < 40; f++) begin
      logic [14:0] w;
      w = 15'($urandom);
      send_bits(w, 0, 14, 1'b1);
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    n = 0;
    while (out_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("final_drain", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/syndrome_checker.md
Name: syndrome_checker

Overview:
Bit-serial front end of the (15,7) one-step majority-logic decoder. It assembles received codeword bits into a 15-bit word and accumulates the 8-bit syndrome of parity-check matrix H715 on the fly. It then presents the word, syndrome and error flag to the downstream majority-logic corrector through a valid/ready handshake. A one-word output buffer lets the next frame be collected while the corrector is still busy.

Parameters:
N, 15, codeword length. Only 15 is supported.
M, 8, syndrome width (rows of H715). Only 8 is supported.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
din  input  1  received bit; frame order is index 0 first, index 14 last
din_valid  input  1  din carries a bit this cycle
din_ready  output  1  block accepts a bit this cycle
cw  output  15  assembled codeword to the corrector; bit j is the j-th received bit
syndrome  output  8  H715 syndrome of cw; bit r is row r
error  output  1  reduction-OR of syndrome
out_valid  output  1  cw, syndrome and error are valid
out_ready  input  1  corrector accepts the word

Behaviour:
- Bit acceptance: a bit is accepted when din_valid and din_ready are both 1 on a rising edge.
- Collector state: bit counter idx (0..14), shift/assembly register asm_w[14:0], syndrome accumulator acc[7:0].
- On each accepted bit at index j: asm_w[j] <= din. If din=1, acc <= acc XOR col(j). idx <= idx+1.
- H715 columns, as hex with bit r = row r:
  - col(j) = 1<<j for j = 0..7
  - col8 = D1, col9 = 73, col10 = E6, col11 = 1D
  - col12 = 3A, col13 = 74, col14 = E8
- Frame completion: when the bit at idx=14 is accepted, the completed word {din-updated asm_w} and its final acc are transferred to the output buffer on that same edge. The transfer is allowed only if the buffer is empty or is being emptied that cycle. Also on that edge, idx <= 0 and acc <= 0.
- Latency: out_valid rises on the first edge after the 15th bit is accepted, i.e. 1 cycle. syndrome and error are registered values, with no combinational path from din.
- Output buffer states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1, and outputs are held stable until out_ready=1.
  - FULL with out_ready=1 goes to EMPTY, unless a new frame completes on the same edge; in that case it stays FULL with the new word loaded (back-to-back, no bubble).
- din_ready:
  - 1 whenever idx<14.
  - At idx=14, din_ready = (buffer EMPTY) OR out_ready. This stalls only the last bit when the buffer cannot accept it. It is combinational from out_ready.
- error = |syndrome, and is valid only while out_valid=1.
- din_valid=0 gaps mid-frame are allowed; the frame resumes with no timeout.
- Reset (asynchronous, any time including mid-frame or with the buffer FULL):
  - idx=0, acc=0, asm_w=0, buffer EMPTY.
  - Outputs: out_valid=0, cw=0, syndrome=0, error=0. din_ready=1 is driven combinationally once rst deasserts.
  - A partial frame is discarded.
- No output changes while out_valid=1 and out_ready=0.

Test Plan:
- All-zero frame, out_ready=1 -> out_valid 1 cycle after bit 14; cw=0000, syndrome=00, error=0.
- Single 1 at index 8 -> cw=0100 hex, syndrome=D1, error=1.
- Single 1 at index 0 -> syndrome=01. Single 1 at index 14 -> syndrome=E8.
- Valid codeword, bits 0,4,6,7,8 set -> cw=01D1 hex, syndrome=00, error=0.
- Back-to-back frames with out_ready held 0 after frame 1:
  - frame 2 stalls at idx=14 with din_ready=0;
  - frame-1 outputs stay stable;
  - raising out_ready for one cycle accepts frame 1 and loads frame 2 on the same edge, with out_valid staying 1.
- Reset case 1: rst pulsed after 7 bits -> out_valid=0 immediately; the next 15-bit all-zero frame yields syndrome=00, with no residue from the aborted frame.
- Reset case 2: rst pulsed with the buffer FULL -> out_valid=0 immediately; the buffered word is dropped.
